// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream input and instruction-memory write bus of the
// instruction memory loader.
//   in_valid  : byte-stream valid (host -> loader)
//   in_data   : byte-stream payload, 8 bits (host -> loader)
//   in_ready  : loader can take a byte this cycle (loader -> host)
//   mem_we    : instruction memory write strobe (loader -> memory)
//   mem_waddr : byte address of the write, bits [1:0] always 0
//   mem_wdata : 32-bit instruction word
// master = stream source / memory sink side, slave = the loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- loads a program into instruction memory from a byte stream.
// Stream format: 16-bit big-endian word count N, then N big-endian 32-bit
// words. Word k is written to byte address 4*k; words beyond DEPTH are
// consumed but not written and raise the sticky error flag.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// checksum byte (XOR of all header and data bytes); a mismatch sets error.
//
// Ports:
//   clk          : system clock, all state on the rising edge
//   reset        : synchronous active-high reset
//   start        : one-cycle pulse opening a session (ignored when busy)
//   bus          : imem_loader_if.slave (byte stream in, memory writes out)
//   busy         : high in every non-idle state; stalls the CPU
//   done         : one-cycle pulse as the loader returns to idle
//   error        : sticky per-session error flag
//   words_loaded : number of words actually written this session
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE} state_t;
`endif

  // One extra bit so a DEPTH equal to 2**CNT_W still compares correctly.
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  state_t           state;
  logic [7:0]       hdr_hi;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] wcnt;      // words consumed so far (index of next word)
  logic [1:0]       bidx;      // byte position within the current word
  logic [23:0]      wbuf;      // first three bytes of the current word

  logic             fire;
  logic [CNT_W-1:0] hdr_n;
  logic             in_range;

  assign fire     = bus.in_valid && bus.in_ready;
  assign hdr_n    = CNT_W'({hdr_hi, bus.in_data});
  assign in_range = {1'b0, wcnt} < DEPTH_C;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of header and data bytes; the checksum byte itself is excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= 8'h00;
    end else if (state == IDLE && start) begin
      csum <= 8'h00;
    end else if (fire && state != CHK) begin
      csum <= csum ^ bus.in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= 32'h0;
      bus.mem_wdata <= 32'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
      wcnt          <= '0;
      bidx          <= 2'd0;
    end else begin
      done       <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= HDR_HI;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            error        <= 1'b0;
            words_loaded <= '0;
            wcnt         <= '0;
            bidx         <= 2'd0;
          end
        end

        HDR_HI: begin
          if (fire) begin
            hdr_hi <= bus.in_data;
            state  <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (fire) begin
            n <= hdr_n;
            if (hdr_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state        <= IDLE;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
`endif
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (fire) begin
            wbuf <= {wbuf[15:0], bus.in_data};
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              // Word complete: present it during the one-cycle WRITE stall.
              state         <= WRITE;
              bus.in_ready  <= 1'b0;
              bus.mem_wdata <= {wbuf, bus.in_data};
              bus.mem_waddr <= 32'(wcnt) << 2;
              wcnt          <= wcnt + 1'b1;
              if (in_range) begin
                bus.mem_we   <= 1'b1;
                words_loaded <= words_loaded + 1'b1;
              end else begin
                error <= 1'b1;
              end
            end
          end
        end

        WRITE: begin
          // wcnt already counts the word just presented.
          if (wcnt == n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state        <= CHK;
            bus.in_ready <= 1'b1;
`else
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end else begin
            state        <= DATA;
            bus.in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (fire) begin
            if (bus.in_data != csum) error <= 1'b1;
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
`endif

        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
